// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard transmitter: a byte FIFO feeding an 11-bit
// device-to-host frame serialiser (start, 8 data LSB first, odd parity, stop).
module ps2_keyboard_tx #(
   parameter int CLK_DIV    = 4,
   parameter int GAP        = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       busy,
   output logic       frame_done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [9:0]  DIV_LAST   = 10'(CLK_DIV - 1);
   localparam logic [9:0]  DIV_PRE    = 10'(CLK_DIV - 2);
   localparam logic [9:0]  GAP_LAST   = 10'(GAP - 1);
   localparam logic [3:0]  STOP_IDX   = 4'd10;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HIGH,
      LOW,
      GAP_S
   } state_t;

   state_t      state_reg, state_next;
   logic [9:0]  cnt_reg, cnt_next;
   logic [3:0]  bit_idx_reg, bit_idx_next;
   logic [10:0] frame_reg;
   logic        ps2_clk_reg, ps2_clk_next;
   logic        ps2_data_reg, ps2_data_next;
   logic        frame_done_reg, frame_done_next;
   logic        busy_reg, busy_next;
   logic        in_ready_reg, in_ready_next;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg, count_next;

   logic push;
   logic pop;
   logic shift;

   assign push = in_valid && in_ready_reg;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // FIFO storage has no reset so it can map onto RAM; the pointers carry validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;
      end
   end

   // Frame shift register: bit 0 is always the next bit to drive; stop bits shift in.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         frame_reg <= '1;
      end else if (pop) begin
         frame_reg <= {1'b1, ~^mem[rd_ptr_reg], mem[rd_ptr_reg], 1'b0};
      end else if (shift) begin
         frame_reg <= {1'b1, frame_reg[10:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         bit_idx_reg    <= '0;
         ps2_clk_reg    <= 1'b1;
         ps2_data_reg   <= 1'b1;
         frame_done_reg <= 1'b0;
         busy_reg       <= 1'b0;
         in_ready_reg   <= 1'b1;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         bit_idx_reg    <= bit_idx_next;
         ps2_clk_reg    <= ps2_clk_next;
         ps2_data_reg   <= ps2_data_next;
         frame_done_reg <= frame_done_next;
         busy_reg       <= busy_next;
         in_ready_reg   <= in_ready_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      bit_idx_next    = bit_idx_reg;
      ps2_clk_next    = ps2_clk_reg;
      ps2_data_next   = ps2_data_reg;
      frame_done_next = 1'b0;
      pop             = 1'b0;
      shift           = 1'b0;

      case (state_reg)
         IDLE: begin
            ps2_clk_next  = 1'b1;
            ps2_data_next = 1'b1;
            cnt_next      = '0;
            if (count_reg != '0) begin
               pop        = 1'b1;
               state_next = LOAD;
            end
         end

         LOAD: begin
            ps2_clk_next  = 1'b1;
            ps2_data_next = frame_reg[0];
            shift         = 1'b1;
            cnt_next      = '0;
            bit_idx_next  = '0;
            state_next    = HIGH;
         end

         HIGH: begin
            if (cnt_reg == DIV_LAST) begin
               cnt_next     = '0;
               ps2_clk_next = 1'b0;
               state_next   = LOW;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         LOW: begin
            // Registered pulse lands in the final low cycle of the stop bit.
            if (cnt_reg == DIV_PRE && bit_idx_reg == STOP_IDX) begin
               frame_done_next = 1'b1;
            end
            if (cnt_reg == DIV_LAST) begin
               cnt_next     = '0;
               ps2_clk_next = 1'b1;
               if (bit_idx_reg == STOP_IDX) begin
                  ps2_data_next = 1'b1;
                  state_next    = GAP_S;
               end else begin
                  bit_idx_next  = bit_idx_reg + 1'b1;
                  ps2_data_next = frame_reg[0];
                  shift         = 1'b1;
                  state_next    = HIGH;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         GAP_S: begin
            ps2_clk_next  = 1'b1;
            ps2_data_next = 1'b1;
            if (cnt_reg == GAP_LAST) begin
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         default: begin
            ps2_clk_next  = 1'b1;
            ps2_data_next = 1'b1;
            cnt_next      = '0;
            state_next    = IDLE;
         end
      endcase
   end

   always_comb begin
      busy_next     = (state_next != IDLE) || (count_next != '0);
      in_ready_next = (count_next != FULL_COUNT);
   end

   assign in_ready   = in_ready_reg;
   assign ps2_clk    = ps2_clk_reg;
   assign ps2_data   = ps2_data_reg;
   assign busy       = busy_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Directed bench: two transmitters (CLK_DIV 4 and 8) each watched by a host-style
// receiver that decodes frames on ps2_clk falling edges.
module tb_ps2_keyboard_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn;
   logic       vld [2];
   logic [7:0] dat [2];
   logic       rdy [2];
   logic       pc  [2];
   logic       pd  [2];
   logic       bsy [2];
   logic       fd  [2];

   ps2_keyboard_tx #(.CLK_DIV(4), .GAP(16), .FIFO_DEPTH(8)) dut0 (
      .clk(clk), .resetn(resetn), .in_valid(vld[0]), .in_data(dat[0]),
      .in_ready(rdy[0]), .ps2_clk(pc[0]), .ps2_data(pd[0]),
      .busy(bsy[0]), .frame_done(fd[0])
   );

   ps2_keyboard_tx #(.CLK_DIV(8), .GAP(16), .FIFO_DEPTH(8)) dut1 (
      .clk(clk), .resetn(resetn), .in_valid(vld[1]), .in_data(dat[1]),
      .in_ready(rdy[1]), .ps2_clk(pc[1]), .ps2_data(pd[1]),
      .busy(bsy[1]), .frame_done(fd[1])
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [10:0] frm_mem   [2][64];
   int          start_cyc [2][64];
   int          stop_cyc  [2][64];
   int          frm_n  [2] = '{0, 0};
   int          fall_n [2] = '{0, 0};
   int          fd_n   [2] = '{0, 0};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Host-side receiver model per channel.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_mon
         localparam int DIV = (gi == 0) ? 4 : 8;
         int         bitn      = 0;
         int         last_fall = 0;
         int         last_stop = 0;
         logic       prevc     = 1'b1;
         logic [9:0] sh        = '0;

         always @(negedge clk) begin
            if (!resetn) begin
               bitn  <= 0;
               prevc <= 1'b1;
            end else begin
               if (prevc && !pc[gi]) begin
                  fall_n[gi] <= fall_n[gi] + 1;
                  last_fall  <= cyc;
                  if (bitn != 0)
                     chk("fall_spacing", 32'(cyc - last_fall), 32'(2 * DIV));
                  else
                     start_cyc[gi][frm_n[gi] % 64] <= cyc;
                  if (bitn == 10) begin
                     chk("rx_start", 32'(sh[0]), 32'd0);
                     chk("rx_stop", 32'(pd[gi]), 32'd1);
                     chk("rx_parity", 32'(sh[9]), 32'(~^sh[8:1]));
                     frm_mem[gi][frm_n[gi] % 64]  <= {pd[gi], sh};
                     stop_cyc[gi][frm_n[gi] % 64] <= cyc;
                     last_stop  <= cyc;
                     frm_n[gi]  <= frm_n[gi] + 1;
                     bitn       <= 0;
                  end else begin
                     sh[bitn] <= pd[gi];
                     bitn     <= bitn + 1;
                  end
               end
               if (fd[gi]) begin
                  fd_n[gi] <= fd_n[gi] + 1;
                  chk("frame_done_pos", 32'(cyc - last_stop), 32'(DIV - 1));
               end
               prevc <= pc[gi];
            end
         end
      end
   endgenerate

   task automatic push(input int ch, input logic [7:0] b);
      int n = 0;
      vld[ch] = 1'b1;
      dat[ch] = b;
      while (!rdy[ch] && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rdy[ch]) chk("push_timeout", 32'd1, 32'd0);
      else begin
         @(posedge clk); #1;
      end
      vld[ch] = 1'b0;
   endtask

   task automatic wait_idle(input int ch, input int budget);
      int n = 0;
      while (bsy[ch] && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_reached", 32'(bsy[ch]), 32'd0);
   endtask

   task automatic wait_fd(input int budget);
      int n = 0;
      while (!fd[0] && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (!fd[0]) chk("frame_done_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_falls(input int ch, input int cnt, input int budget);
      int n = 0;
      int target;
      target = fall_n[ch] + cnt;
      while (fall_n[ch] < target && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (fall_n[ch] < target) chk("falls_timeout", 32'd1, 32'd0);
   endtask

   logic [7:0] fifo_bytes  [10] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89,
                                    8'hAB, 8'hCD, 8'hEF, 8'h3C, 8'h5A};
   logic [7:0] simul_bytes [10] = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65,
                                    8'h76, 8'h87, 8'h98, 8'hA9, 8'hBA};
   logic [7:0] loop_bytes  [6]  = '{8'h1C, 8'hF0, 8'h1C, 8'h32, 8'hF0, 8'h32};

   initial begin
      int base;
      int fb;
      int fdb;
      resetn = 1'b0;
      vld[0] = 1'b0; vld[1] = 1'b0;
      dat[0] = 8'h00; dat[1] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ps2_clk", 32'(pc[0]), 32'd1);
      chk("rst_ps2_data", 32'(pd[0]), 32'd1);
      chk("rst_busy", 32'(bsy[0]), 32'd0);
      chk("rst_frame_done", 32'(fd[0]), 32'd0);
      chk("rst_in_ready", 32'(rdy[0]), 32'd1);
      resetn = 1'b1;
      @(posedge clk); #1;

      // single byte 0x1C with latency and gap timing
      base = frm_n[0]; fb = fall_n[0]; fdb = fd_n[0];
      push(0, 8'h1C);
      $display("push 0x1c ch0");
      chk("busy_after_push", 32'(bsy[0]), 32'd1);
      chk("data_idle_e0", 32'(pd[0]), 32'd1);
      @(posedge clk); #1;
      chk("data_high_e1", 32'(pd[0]), 32'd1);
      @(posedge clk); #1;
      chk("start_low_e2", 32'(pd[0]), 32'd0);
      chk("clk_high_e2", 32'(pc[0]), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("clk_high_e5", 32'(pc[0]), 32'd1);
      @(posedge clk); #1;
      chk("first_fall_e6", 32'(pc[0]), 32'd0);
      wait_fd(500);
      repeat (16) @(posedge clk);
      #1;
      chk("busy_in_gap", 32'(bsy[0]), 32'd1);
      chk("gap_clk_high", 32'(pc[0]), 32'd1);
      chk("gap_data_high", 32'(pd[0]), 32'd1);
      @(posedge clk); #1;
      chk("busy_after_gap", 32'(bsy[0]), 32'd0);
      chk("t1_frames", 32'(frm_n[0] - base), 32'd1);
      chk("t1_frame_bits", 32'(frm_mem[0][base % 64]), 32'h438);
      chk("t1_falls", 32'(fall_n[0] - fb), 32'd11);
      chk("t1_frame_done_cnt", 32'(fd_n[0] - fdb), 32'd1);
      $display("frame ch0 bits=0x%0h", frm_mem[0][base % 64]);

      // break sequence back to back
      base = frm_n[0]; fb = fall_n[0];
      push(0, 8'hF0);
      push(0, 8'h1C);
      $display("push 0xf0 0x1c ch0");
      wait_idle(0, 1000);
      chk("t2_frames", 32'(frm_n[0] - base), 32'd2);
      chk("t2_f0_bits", 32'(frm_mem[0][base % 64]), 32'h7E0);
      chk("t2_1c_bits", 32'(frm_mem[0][(base + 1) % 64]), 32'h438);
      chk("t2_interframe", 32'(start_cyc[0][(base + 1) % 64] - stop_cyc[0][base % 64]), 32'd26);
      chk("t2_period", 32'(start_cyc[0][(base + 1) % 64] - start_cyc[0][base % 64]), 32'd106);
      chk("t2_falls", 32'(fall_n[0] - fb), 32'd22);

      // FIFO full with in_valid held
      base = frm_n[0];
      for (int i = 0; i < 9; i++) begin
         push(0, fifo_bytes[i]);
         if (i == 7) chk("ready_before_full", 32'(rdy[0]), 32'd1);
      end
      chk("ready_when_full", 32'(rdy[0]), 32'd0);
      push(0, fifo_bytes[9]);
      wait_idle(0, 3000);
      chk("t3_frames", 32'(frm_n[0] - base), 32'd10);
      for (int i = 0; i < 10; i++) begin
         chk("fifo_order", 32'(frm_mem[0][(base + i) % 64][8:1]), 32'(fifo_bytes[i]));
         $display("fifo frame %0d data=0x%0h", i, frm_mem[0][(base + i) % 64][8:1]);
      end

      // push coinciding with pop while three entries are queued
      base = frm_n[0];
      for (int i = 0; i < 4; i++) push(0, simul_bytes[i]);
      wait_fd(500);
      repeat (17) @(posedge clk);
      #1;
      push(0, simul_bytes[4]);
      for (int i = 5; i < 9; i++) push(0, simul_bytes[i]);
      chk("simul_ready_at7", 32'(rdy[0]), 32'd1);
      push(0, simul_bytes[9]);
      chk("simul_ready_at8", 32'(rdy[0]), 32'd0);
      wait_idle(0, 3000);
      chk("t6_frames", 32'(frm_n[0] - base), 32'd10);
      for (int i = 0; i < 10; i++) begin
         chk("simul_order", 32'(frm_mem[0][(base + i) % 64][8:1]), 32'(simul_bytes[i]));
         $display("simul frame %0d data=0x%0h", i, frm_mem[0][(base + i) % 64][8:1]);
      end

      // reset during bit 5 of 0xAA
      base = frm_n[0]; fb = fall_n[0];
      push(0, 8'hAA);
      wait_falls(0, 6, 500);
      resetn = 1'b0;
      @(posedge clk); #1;
      chk("midrst_clk", 32'(pc[0]), 32'd1);
      chk("midrst_data", 32'(pd[0]), 32'd1);
      chk("midrst_busy", 32'(bsy[0]), 32'd0);
      chk("midrst_ready", 32'(rdy[0]), 32'd1);
      resetn = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("no_resend_busy", 32'(bsy[0]), 32'd0);
      chk("no_resend_falls", 32'(fall_n[0] - fb), 32'd6);
      push(0, 8'h55);
      wait_idle(0, 1000);
      chk("t4_frames", 32'(frm_n[0] - base), 32'd1);
      chk("t4_55_bits", 32'(frm_mem[0][base % 64]), 32'h6AA);
      $display("after reset frame bits=0x%0h", frm_mem[0][base % 64]);

      // loopback at CLK_DIV=8
      base = frm_n[1];
      for (int i = 0; i < 6; i++) push(1, loop_bytes[i]);
      wait_idle(1, 3000);
      chk("t5_frames", 32'(frm_n[1] - base), 32'd6);
      for (int i = 0; i < 6; i++) begin
         chk("loop_byte", 32'(frm_mem[1][(base + i) % 64][8:1]), 32'(loop_bytes[i]));
         $display("loop frame %0d data=0x%0h", i, frm_mem[1][(base + i) % 64][8:1]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
